// File: rtl/riscv_trace_buffer.sv
// Retired-instruction trace FIFO: captures one record per retire strobe, drops and counts on overflow.
// Optional macro TRACE_PC_FILTER_EN adds an inclusive unsigned PC window filter (filter_lo_i..filter_hi_i).
module riscv_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     flush_i,
  input  logic                     update_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  input  logic                     mem_wrt_i,
  input  logic                     mem_read_i,
  input  logic [XLEN-1:0]          mem_addr_i,
  input  logic [XLEN-1:0]          mem_data_i,
`ifdef TRACE_PC_FILTER_EN
  input  logic [XLEN-1:0]          filter_lo_i,
  input  logic [XLEN-1:0]          filter_hi_i,
`endif
  output logic                     rec_valid_o,
  input  logic                     rec_ready_i,
  output logic [XLEN-1:0]          rec_pc_o,
  output logic [XLEN-1:0]          rec_instr_o,
  output logic [4:0]               rec_reg_addr_o,
  output logic [XLEN-1:0]          rec_reg_data_o,
  output logic                     rec_mem_wrt_o,
  output logic                     rec_mem_read_o,
  output logic [XLEN-1:0]          rec_mem_addr_o,
  output logic [XLEN-1:0]          rec_mem_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("riscv_trace_buffer: DEPTH must be a power of two and at least 2");
  end

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] reg_data;
    logic            mem_wrt;
    logic            mem_read;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
  } rec_t;

  rec_t            r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic [15:0]     r_drop_cnt;

  logic            w_pass;
  logic            w_req;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  rec_t            w_in;
  rec_t            w_head;

`ifdef TRACE_PC_FILTER_EN
  assign w_pass = (pc_i >= filter_lo_i) && (pc_i <= filter_hi_i);
`else
  assign w_pass = 1'b1;
`endif

  assign w_req  = update_i && enable_i && w_pass;
  assign w_pop  = (r_count != '0) && rec_ready_i;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push = w_req && ((r_count != FULL) || w_pop);
  assign w_drop = w_req && !w_push;

  assign w_in = '{pc: pc_i, instr: instr_i, reg_addr: reg_addr_i, reg_data: reg_data_i,
                  mem_wrt: mem_wrt_i, mem_read: mem_read_i, mem_addr: mem_addr_i,
                  mem_data: mem_data_i};

  // Storage is deliberately unreset; rec_* is don't-care while empty.
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) r_mem[r_wptr] <= w_in;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (flush_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign w_head         = r_mem[r_rptr];
  assign rec_valid_o    = (r_count != '0);
  assign rec_pc_o       = w_head.pc;
  assign rec_instr_o    = w_head.instr;
  assign rec_reg_addr_o = w_head.reg_addr;
  assign rec_reg_data_o = w_head.reg_data;
  assign rec_mem_wrt_o  = w_head.mem_wrt;
  assign rec_mem_read_o = w_head.mem_read;
  assign rec_mem_addr_o = w_head.mem_addr;
  assign rec_mem_data_o = w_head.mem_data;
  assign count_o        = r_count;
  assign overflow_o     = r_overflow;
  assign drop_cnt_o     = r_drop_cnt;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Bench for riscv_trace_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_riscv_trace_buffer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] reg_data;
    logic            mem_wrt;
    logic            mem_read;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
  } trec_t;

  logic clk_i = 0, rst_i = 1, enable_i = 0, flush_i = 0, update_i = 0, rec_ready_i = 0;
  trec_t in_rec = '0;
  logic [XLEN-1:0] filt_lo = '0, filt_hi = '1;
  logic rec_valid_o, rec_mem_wrt_o, rec_mem_read_o, overflow_o;
  logic [XLEN-1:0] rec_pc_o, rec_instr_o, rec_reg_data_o, rec_mem_addr_o, rec_mem_data_o;
  logic [4:0] rec_reg_addr_o;
  logic [CW-1:0] count_o;
  logic [15:0] drop_cnt_o;

  riscv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .flush_i(flush_i), .update_i(update_i),
    .pc_i(in_rec.pc), .instr_i(in_rec.instr), .reg_addr_i(in_rec.reg_addr),
    .reg_data_i(in_rec.reg_data), .mem_wrt_i(in_rec.mem_wrt), .mem_read_i(in_rec.mem_read),
    .mem_addr_i(in_rec.mem_addr), .mem_data_i(in_rec.mem_data),
`ifdef TRACE_PC_FILTER_EN
    .filter_lo_i(filt_lo), .filter_hi_i(filt_hi),
`endif
    .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i), .rec_pc_o(rec_pc_o),
    .rec_instr_o(rec_instr_o), .rec_reg_addr_o(rec_reg_addr_o), .rec_reg_data_o(rec_reg_data_o),
    .rec_mem_wrt_o(rec_mem_wrt_o), .rec_mem_read_o(rec_mem_read_o),
    .rec_mem_addr_o(rec_mem_addr_o), .rec_mem_data_o(rec_mem_data_o),
    .count_o(count_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o));

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_fail = 0;
  trec_t mq[$];
  bit m_ovf = 0;
  int m_drop = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic trec_t rand_rec(input logic [XLEN-1:0] pc);
    trec_t r;
    r.pc = pc; r.instr = $urandom; r.reg_addr = 5'($urandom); r.reg_data = $urandom;
    r.mem_wrt = 1'($urandom); r.mem_read = 1'($urandom);
    r.mem_addr = $urandom; r.mem_data = $urandom;
    return r;
  endfunction

  function automatic bit in_window(input logic [XLEN-1:0] pc);
`ifdef TRACE_PC_FILTER_EN
    return (pc >= filt_lo) && (pc <= filt_hi);
`else
    return 1'b1;
`endif
  endfunction

  // Apply current inputs for one clock: update the model, then check the DUT after the edge.
  task automatic step(input string tag);
    trec_t head;
    if (flush_i) begin
      mq.delete(); m_ovf = 0; m_drop = 0;
    end else begin
      bit req;
      req = update_i && enable_i && in_window(in_rec.pc);
      if (mq.size() > 0 && rec_ready_i) void'(mq.pop_front());
      if (req) begin
        if (mq.size() < DEPTH) mq.push_back(in_rec);
        else begin
          m_ovf = 1;
          if (m_drop < 16'hFFFF) m_drop++;
        end
      end
    end
    @(posedge clk_i); #1;
    chk({tag, ".count"}, 256'(count_o), 256'(mq.size()));
    chk({tag, ".valid"}, 256'(rec_valid_o), 256'(mq.size() != 0));
    chk({tag, ".ovf"}, 256'(overflow_o), 256'(m_ovf));
    chk({tag, ".drop"}, 256'(drop_cnt_o), 256'(m_drop));
    if (mq.size() > 0) begin
      head = mq[0];
      chk({tag, ".head"}, 256'({rec_pc_o, rec_instr_o, rec_reg_addr_o, rec_reg_data_o,
          rec_mem_wrt_o, rec_mem_read_o, rec_mem_addr_o, rec_mem_data_o}), 256'(head));
    end
  endtask

  task automatic retire(input logic [XLEN-1:0] pc, input bit rdy, input string tag);
    update_i = 1; enable_i = 1; rec_ready_i = rdy; in_rec = rand_rec(pc);
    step(tag);
  endtask

  task automatic idle(input bit rdy, input string tag);
    update_i = 0; rec_ready_i = rdy;
    step(tag);
  endtask

  trec_t first;

  initial begin
    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst.count", 256'(count_o), 256'(0));
    chk("rst.valid", 256'(rec_valid_o), 256'(0));
    chk("rst.ovf", 256'(overflow_o), 256'(0));
    chk("rst.drop", 256'(drop_cnt_o), 256'(0));
    @(negedge clk_i); rst_i = 0;
    @(posedge clk_i); #1;

    // Three retires drained as they arrive
    retire(32'h0, 1, "seq0"); chk("seq0.pc", 256'(rec_pc_o), 256'(32'h0));
    retire(32'h4, 1, "seq1"); chk("seq1.pc", 256'(rec_pc_o), 256'(32'h4));
    retire(32'h8, 1, "seq2"); chk("seq2.pc", 256'(rec_pc_o), 256'(32'h8));
    idle(1, "seq3"); chk("seq3.count0", 256'(count_o), 256'(0));

    // Overfill with consumer stalled
    for (int i = 0; i < DEPTH + 2; i++) begin
      retire(32'h1000 + 32'(i * 4), 0, "fill");
      if (i == 0) first = in_rec;
    end
    chk("ovf.count", 256'(count_o), 256'(DEPTH));
    chk("ovf.drop", 256'(drop_cnt_o), 256'(2));
    chk("ovf.flag", 256'(overflow_o), 256'(1));
    chk("ovf.head", 256'(rec_pc_o), 256'(first.pc));
    idle(0, "hold");
    chk("hold.head", 256'(rec_instr_o), 256'(first.instr));

    // Full with simultaneous push and pop
    retire(32'h2000, 1, "fullpp");
    chk("fullpp.count", 256'(count_o), 256'(DEPTH));
    chk("fullpp.drop", 256'(drop_cnt_o), 256'(2));
    chk("fullpp.head", 256'(rec_pc_o), 256'(32'h1004));

    // Flush beats a concurrent push and pop
    flush_i = 1; retire(32'h3000, 1, "flush"); flush_i = 0;
    chk("flush.count", 256'(count_o), 256'(0));
    chk("flush.ovf", 256'(overflow_o), 256'(0));
    chk("flush.drop", 256'(drop_cnt_o), 256'(0));
    idle(1, "empty_rdy");

`ifdef TRACE_PC_FILTER_EN
    filt_lo = 32'h100; filt_hi = 32'h1FF;
    retire(32'hFC, 0, "flt0"); retire(32'h100, 0, "flt1");
    retire(32'h1FF, 0, "flt2"); retire(32'h200, 0, "flt3");
    chk("flt.count", 256'(count_o), 256'(2));
    chk("flt.drop", 256'(drop_cnt_o), 256'(0));
    chk("flt.head0", 256'(rec_pc_o), 256'(32'h100));
    idle(1, "flt4");
    chk("flt.head1", 256'(rec_pc_o), 256'(32'h1FF));
    idle(1, "flt5");
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      update_i = ($urandom_range(0, 99) < 70);
      enable_i = ($urandom_range(0, 99) < 90);
      rec_ready_i = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 75));
      flush_i = ($urandom_range(0, 99) < 2);
      in_rec = rand_rec(32'($urandom_range(32'hF0, 32'h210)));
      step("rnd");
    end
    flush_i = 0;

    // Async reset with five entries queued
    flush_i = 1; idle(0, "pre"); flush_i = 0;
    for (int i = 0; i < 5; i++) retire(32'h180 + 32'(i * 4), 0, "five");
    chk("five.count", 256'(count_o), 256'(5));
    rec_ready_i = 1;
    #3 rst_i = 1;
    #1;
    chk("arst.valid", 256'(rec_valid_o), 256'(0));
    chk("arst.count", 256'(count_o), 256'(0));
    mq.delete(); m_ovf = 0; m_drop = 0;
    update_i = 1; in_rec = rand_rec(32'h1C0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_i = 0;
    retire(32'h1A0, 0, "post");
    chk("post.pc", 256'(rec_pc_o), 256'(32'h1A0));
    retire(32'h1A4, 1, "post2");
    chk("post2.pc", 256'(rec_pc_o), 256'(32'h1A4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, limit 2000000 required less");
    $fatal(1);
  end
endmodule
